spi_cfg_frame_decoder: RTL and testbench

Sits directly downstream of the SPI peripheral and upstream of the top-level configuration register. It parses received SPI bytes into framed commands and assembles 32-bit configuration words. New words are held in a shadow register and committed only at a vertical-blank boundary, so the pixel mux, character row and pong select never change mid-frame. It also serves config read-back bytes to the peripheral for MISO.

---
 rtl/spi_cfg_frame_decoder_pkg.sv | 34 +++
 rtl/spi_cfg_frame_decoder_crc.sv | 21 ++
 rtl/spi_cfg_frame_decoder.sv | 194 +++++++++++++++++++
 tb/tb_spi_cfg_frame_decoder.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_cfg_frame_decoder_pkg.sv
// Shared opcodes, FSM encoding and CRC constants for the SPI config decoder.
// CFG_FRAME_CRC_EN adds a CRC-8 trailer byte to WRITE_CFG frames.
package spi_cfg_frame_decoder_pkg;

    localparam logic [7:0] OP_NOP       = 8'h00;
    localparam logic [7:0] OP_WRITE_CFG = 8'hA1;
    localparam logic [7:0] OP_READ_CFG  = 8'hA2;

    localparam logic [7:0]  CRC_POLY      = 8'h07;
    localparam logic [31:0] RESET_CFG_DEF = 32'hBBFC0000;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_CMD     = 3'd1;
    localparam state_t ST_WDATA   = 3'd2;
    localparam state_t ST_RDATA   = 3'd3;
    localparam state_t ST_CHK     = 3'd4;
    localparam state_t ST_DONE    = 3'd5;
    localparam state_t ST_DISCARD = 3'd6;

    function automatic logic [7:0] rd_byte(
        input logic [31:0] w,
        input logic [2:0]  idx
    );
        case (idx)
            3'd1:    rd_byte = w[23:16];
            3'd2:    rd_byte = w[15:8];
            3'd3:    rd_byte = w[7:0];
            default: rd_byte = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/spi_cfg_frame_decoder_crc.sv
// Combinational byte-step CRC-8 (MSB first, no reflection).
// Only instantiated when CFG_FRAME_CRC_EN is defined.
module cfg_crc8
    import spi_cfg_frame_decoder_pkg::*;
(
    input  logic [7:0] crc,
    input  logic [7:0] data,
    output logic [7:0] crc_next
);

    logic [7:0] c;

    always_comb begin
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
        end
        crc_next = c;
    end

endmodule

// File: rtl/spi_cfg_frame_decoder.sv
// SPI config frame decoder: shadowed 32-bit config, vblank commit, read-back.
// Define CFG_FRAME_CRC_EN to require a CRC-8 trailer on WRITE_CFG.
module spi_cfg_frame_decoder
    import spi_cfg_frame_decoder_pkg::*;
#(
    parameter logic [31:0] RESET_CFG = RESET_CFG_DEF,
    parameter int          ERR_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ss_n,
    input  logic [7:0]       rx_byte,
    input  logic             rx_valid,
    input  logic             vblank_pulse,
    output logic [7:0]       tx_byte,
    output logic             tx_load,
    output logic [31:0]      cfg_out,
    output logic             cfg_commit,
    output logic             pending,
    output logic [ERR_W-1:0] err_count
);

`ifdef CFG_FRAME_CRC_EN
    localparam int ASM_W = 32;
`else
    localparam int ASM_W = 24;
`endif

    state_t             state_q;
    state_t             state_n;
    logic [2:0]         idx_q;
    logic [ASM_W-1:0]   asm_q;
    logic [31:0]        asm_next;
    logic [31:0]        snap_q;
    logic [31:0]        shadow_q;
    logic [31:0]        cfg_q;
    logic               pending_q;
    logic               commit_q;
    logic [7:0]         tx_byte_q;
    logic               tx_load_q;
    logic [ERR_W-1:0]   err_q;
    logic               byte_ok;
    logic               wr_done;
    logic               err_inc;
    logic [31:0]        wr_word;

`ifdef CFG_FRAME_CRC_EN
    logic [7:0] crc_q;
    logic [7:0] crc_nx;

    cfg_crc8 u_crc (
        .crc      (crc_q),
        .data     (rx_byte),
        .crc_next (crc_nx)
    );
`endif

    assign byte_ok  = rx_valid & ~ss_n;
    assign asm_next = {asm_q[23:0], rx_byte};

`ifdef CFG_FRAME_CRC_EN
    assign wr_word = asm_q;
`else
    assign wr_word = asm_next;
`endif

    always_comb begin
        state_n = state_q;
        wr_done = 1'b0;
        err_inc = 1'b0;
        if (ss_n) begin
            // Losing select mid-write is the only abort that counts
            state_n = ST_IDLE;
            err_inc = (state_q == ST_WDATA) || (state_q == ST_CHK);
        end else begin
            case (state_q)
                ST_IDLE: state_n = ST_CMD;
                ST_CMD: begin
                    if (byte_ok) begin
                        case (rx_byte)
                            OP_WRITE_CFG: state_n = ST_WDATA;
                            OP_READ_CFG:  state_n = ST_RDATA;
                            OP_NOP:       state_n = ST_DONE;
                            default: begin
                                state_n = ST_DISCARD;
                                err_inc = 1'b1;
                            end
                        endcase
                    end
                end
                ST_WDATA: begin
                    if (byte_ok && idx_q == 3'd3) begin
`ifdef CFG_FRAME_CRC_EN
                        state_n = ST_CHK;
`else
                        state_n = ST_DONE;
                        wr_done = 1'b1;
`endif
                    end
                end
`ifdef CFG_FRAME_CRC_EN
                ST_CHK: begin
                    if (byte_ok) begin
                        if (rx_byte == crc_q) begin
                            state_n = ST_DONE;
                            wr_done = 1'b1;
                        end else begin
                            state_n = ST_DISCARD;
                            err_inc = 1'b1;
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= 3'd0;
            asm_q     <= '0;
            snap_q    <= RESET_CFG;
            shadow_q  <= RESET_CFG;
            cfg_q     <= RESET_CFG;
            pending_q <= 1'b0;
            commit_q  <= 1'b0;
            tx_byte_q <= 8'h00;
            tx_load_q <= 1'b0;
            err_q     <= '0;
        end else begin
            state_q   <= state_n;
            tx_load_q <= 1'b0;
            commit_q  <= 1'b0;

            if (err_inc && err_q != {ERR_W{1'b1}})
                err_q <= err_q + {{(ERR_W-1){1'b0}}, 1'b1};

            if (state_q == ST_CMD && byte_ok) begin
                idx_q <= 3'd0;
                if (rx_byte == OP_READ_CFG) begin
                    snap_q    <= cfg_q;
                    tx_byte_q <= cfg_q[31:24];
                    tx_load_q <= 1'b1;
                    idx_q     <= 3'd1;
                end
            end

            if (state_q == ST_WDATA && byte_ok) begin
                asm_q <= asm_next[ASM_W-1:0];
                idx_q <= idx_q + 3'd1;
            end

            if (state_q == ST_RDATA && byte_ok) begin
                tx_byte_q <= rd_byte(snap_q, idx_q);
                tx_load_q <= 1'b1;
                if (idx_q != 3'd4)
                    idx_q <= idx_q + 3'd1;
            end

            if (vblank_pulse && pending_q) begin
                cfg_q     <= shadow_q;
                commit_q  <= 1'b1;
                pending_q <= 1'b0;
            end

            // A word finishing on a vblank cycle waits for the next one
            if (wr_done) begin
                shadow_q  <= wr_word;
                pending_q <= 1'b1;
            end
        end
    end

`ifdef CFG_FRAME_CRC_EN
    always_ff @(posedge clk) begin
        if (rst)
            crc_q <= 8'h00;
        else if (state_q == ST_IDLE)
            crc_q <= 8'h00;
        else if (byte_ok && (state_q == ST_CMD || state_q == ST_WDATA))
            crc_q <= crc_nx;
    end
`endif

    assign tx_byte    = tx_byte_q;
    assign tx_load    = tx_load_q;
    assign cfg_out    = cfg_q;
    assign cfg_commit = commit_q;
    assign pending    = pending_q;
    assign err_count  = err_q;

endmodule

// File: tb/tb_spi_cfg_frame_decoder.sv
// Directed self-checking bench for spi_cfg_frame_decoder.
// Honours CFG_FRAME_CRC_EN to append CRC trailers to writes.
module tb_spi_cfg_frame_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        ss_n;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        vblank_pulse;
    logic [7:0]  tx_byte;
    logic        tx_load;
    logic [31:0] cfg_out;
    logic        cfg_commit;
    logic        pending;
    logic [3:0]  err_count;

    int n_assert = 0;
    int n_fail   = 0;
    int n_commit = 0;
    int c0;
    int exp_err;
    logic [31:0] exp_cfg;

    spi_cfg_frame_decoder dut (
        .clk          (clk),
        .rst          (rst),
        .ss_n         (ss_n),
        .rx_byte      (rx_byte),
        .rx_valid     (rx_valid),
        .vblank_pulse (vblank_pulse),
        .tx_byte      (tx_byte),
        .tx_load      (tx_load),
        .cfg_out      (cfg_out),
        .cfg_commit   (cfg_commit),
        .pending      (pending),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (cfg_commit === 1'b1) n_commit++;

    function automatic logic [7:0] crc8(
        input logic [7:0] crc,
        input logic [7:0] d
    );
        logic [7:0] c;
        c = crc ^ d;
        for (int i = 0; i < 8; i++)
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        return c;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input bit vb);
        rx_byte      = b;
        rx_valid     = 1'b1;
        vblank_pulse = vb;
        step();
        rx_valid     = 1'b0;
        vblank_pulse = 1'b0;
    endtask

    task automatic vblank();
        vblank_pulse = 1'b1;
        step();
        vblank_pulse = 1'b0;
    endtask

    task automatic wr_frame(input logic [31:0] w, input bit vb_last);
        logic [7:0] c;
        c = crc8(8'h00, 8'hA1);
        c = crc8(c, w[31:24]);
        c = crc8(c, w[23:16]);
        c = crc8(c, w[15:8]);
        c = crc8(c, w[7:0]);
        ss_n = 1'b0;
        step();
        send(8'hA1, 1'b0);
        send(w[31:24], 1'b0);
        send(w[23:16], 1'b0);
        send(w[15:8], 1'b0);
`ifdef CFG_FRAME_CRC_EN
        send(w[7:0], 1'b0);
        send(c, vb_last);
`else
        send(w[7:0], vb_last);
`endif
        ss_n = 1'b1;
        step();
    endtask

    task automatic chk(
        input string       tag,
        input logic [31:0] obs,
        input logic [31:0] exp
    );
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] bc;
        rst          = 1'b1;
        ss_n         = 1'b1;
        rx_byte      = 8'h00;
        rx_valid     = 1'b0;
        vblank_pulse = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        chk("rst_cfg", cfg_out, 32'hBBFC0000);
        chk("rst_pend", {31'd0, pending}, 0);
        chk("rst_commit", {31'd0, cfg_commit}, 0);
        chk("rst_err", {28'd0, err_count}, 0);
        chk("rst_txb", {24'd0, tx_byte}, 0);
        chk("rst_txl", {31'd0, tx_load}, 0);

        c0 = n_commit;
        repeat (3) vblank();
        step();
        chk("idle_vb_cfg", cfg_out, 32'hBBFC0000);
        chk("idle_vb_ncommit", n_commit - c0, 0);
        chk("idle_vb_pend", {31'd0, pending}, 0);

        send(8'hA1, 1'b0);
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        send(8'h44, 1'b0);
        chk("ssn_hi_ignore_pend", {31'd0, pending}, 0);
        chk("ssn_hi_ignore_err", {28'd0, err_count}, 0);

        wr_frame(32'h12345678, 1'b0);
        chk("wr_pend", {31'd0, pending}, 1);
        chk("wr_cfg_hold", cfg_out, 32'hBBFC0000);
        vblank();
        chk("wr_commit", {31'd0, cfg_commit}, 1);
        chk("wr_cfg", cfg_out, 32'h12345678);
        chk("wr_pend_clr", {31'd0, pending}, 0);
        step();
        chk("wr_commit_1cyc", {31'd0, cfg_commit}, 0);

        c0 = n_commit;
        wr_frame(32'h11223344, 1'b0);
        wr_frame(32'h55667788, 1'b0);
        vblank();
        step();
        vblank();
        step();
        chk("lastwr_cfg", cfg_out, 32'h55667788);
        chk("lastwr_ncommit", n_commit - c0, 1);

        wr_frame(32'hAABBCCDD, 1'b1);
        chk("coinc_no_commit", cfg_out, 32'h55667788);
        chk("coinc_pend", {31'd0, pending}, 1);
        vblank();
        chk("coinc_next_vb", cfg_out, 32'hAABBCCDD);
        chk("coinc_commit", {31'd0, cfg_commit}, 1);

        wr_frame(32'h12345678, 1'b0);
        vblank();
        wr_frame(32'hCAFEBABE, 1'b0);
        ss_n = 1'b0;
        step();
        send(8'hA2, 1'b0);
        chk("rd0_load", {31'd0, tx_load}, 1);
        chk("rd0_byte", {24'd0, tx_byte}, 32'h12);
        step();
        chk("rd_load_pulse", {31'd0, tx_load}, 0);
        vblank();
        chk("rd_mid_commit", cfg_out, 32'hCAFEBABE);
        send(8'hFF, 1'b0);
        chk("rd1_load", {31'd0, tx_load}, 1);
        chk("rd1_byte", {24'd0, tx_byte}, 32'h34);
        send(8'hFF, 1'b0);
        chk("rd2_byte", {24'd0, tx_byte}, 32'h56);
        send(8'hFF, 1'b0);
        chk("rd3_byte", {24'd0, tx_byte}, 32'h78);
        send(8'hFF, 1'b0);
        chk("rd4_load", {31'd0, tx_load}, 1);
        chk("rd4_byte", {24'd0, tx_byte}, 32'h00);
        ss_n = 1'b1;
        step();
        chk("rd_err", {28'd0, err_count}, 0);
        exp_err = 0;
        exp_cfg = 32'hCAFEBABE;

`ifdef CFG_FRAME_CRC_EN
        bc = crc8(8'h00, 8'hA1);
        bc = crc8(bc, 8'h12);
        bc = crc8(bc, 8'h34);
        bc = crc8(bc, 8'h56);
        bc = crc8(bc, 8'h78);
        ss_n = 1'b0;
        step();
        send(8'hA1, 1'b0);
        send(8'h12, 1'b0);
        send(8'h34, 1'b0);
        send(8'h56, 1'b0);
        send(8'h78, 1'b0);
        send(bc ^ 8'h01, 1'b0);
        ss_n = 1'b1;
        step();
        exp_err = exp_err + 1;
        chk("crc_bad_pend", {31'd0, pending}, 0);
        chk("crc_bad_err", {28'd0, err_count}, exp_err);
`else
        bc = 8'h05;
        ss_n = 1'b0;
        step();
        send(8'hA1, 1'b0);
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        send(8'h04, 1'b0);
        send(bc, 1'b0);
        ss_n = 1'b1;
        step();
        chk("x5_pend", {31'd0, pending}, 1);
        chk("x5_err", {28'd0, err_count}, exp_err);
        vblank();
        exp_cfg = 32'h01020304;
        chk("x5_cfg", cfg_out, exp_cfg);
`endif

        ss_n = 1'b0;
        step();
        send(8'h00, 1'b0);
        send(8'h12, 1'b0);
        ss_n = 1'b1;
        step();
        chk("nop_err", {28'd0, err_count}, exp_err);
        chk("nop_pend", {31'd0, pending}, 0);

        ss_n = 1'b0;
        step();
        send(8'hA1, 1'b0);
        send(8'hAB, 1'b0);
        send(8'hCD, 1'b0);
        ss_n = 1'b1;
        step();
        exp_err = exp_err + 1;
        chk("abort_err", {28'd0, err_count}, exp_err);
        chk("abort_pend", {31'd0, pending}, 0);
        vblank();
        chk("abort_no_commit", {31'd0, cfg_commit}, 0);
        chk("abort_cfg", cfg_out, exp_cfg);

        ss_n = 1'b0;
        step();
        send(8'h5F, 1'b0);
        ss_n = 1'b1;
        step();
        exp_err = exp_err + 1;
        chk("badop_err", {28'd0, err_count}, exp_err);

        for (int i = 0; i < 20; i++) begin
            ss_n = 1'b0;
            step();
            send(8'h5F, 1'b0);
            ss_n = 1'b1;
            step();
        end
        chk("err_sat", {28'd0, err_count}, 32'hF);

        ss_n = 1'b0;
        step();
        send(8'hA1, 1'b0);
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_err", {28'd0, err_count}, 0);
        chk("midrst_cfg", cfg_out, 32'hBBFC0000);
        chk("midrst_pend", {31'd0, pending}, 0);
        ss_n = 1'b1;
        step();
        step();
        chk("midrst_no_abort", {28'd0, err_count}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
